// File: rtl/riscv_rf_pkg.sv
// Shared definitions for the RI5CY register-file write-side controller:
// FSM state type, FP bank-select bit and the scrub word count.
package riscv_rf_pkg;

    localparam int unsigned FP_BANK_BIT = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // Words to scrub: the FP bank only exists when FP operands are not in X.
    function automatic int unsigned rf_ntot(input int unsigned fpu, input int unsigned zfinx);
        return (fpu == 1 && zfinx == 0) ? 64 : 32;
    endfunction

endpackage

// File: rtl/riscv_rf_write_ctrl_if.sv
// Write-request handshake bundle between the EX/LSU/debug sources and the
// register-file write controller.
interface riscv_rf_write_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ex_we_i;
    logic [ADDR_WIDTH-1:0] ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;
    logic                  ex_gnt_o;

    logic                  lsu_we_i;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_gnt_o;

    logic                  dbg_req_i;
    logic [ADDR_WIDTH-1:0] dbg_addr_i;
    logic [DATA_WIDTH-1:0] dbg_wdata_i;
    logic                  dbg_gnt_o;

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        output dbg_req_i, dbg_addr_i, dbg_wdata_i,
        input  ex_gnt_o, lsu_gnt_o, dbg_gnt_o
    );

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        input  dbg_req_i, dbg_addr_i, dbg_wdata_i,
        output ex_gnt_o, lsu_gnt_o, dbg_gnt_o
    );

endinterface

// File: rtl/riscv_rf_wport_reg.sv
// Registered register-file write port. Outputs are zero when nothing is
// granted; a granted but suppressed write keeps address/data with we low.
module riscv_rf_wport_reg #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  suppress,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    always_ff @(posedge clk) begin
        if (!rst_n || !valid) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we    <= ~suppress;
            waddr <= addr;
            wdata <= data;
        end
    end

endmodule

// File: rtl/riscv_rf_write_ctrl.sv
// RI5CY register-file write controller: scrubs storage after reset, then
// arbitrates EX (port B) and LSU/debug (port A) writes.
module riscv_rf_write_ctrl
    import riscv_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FPU        = 0,
    parameter int unsigned Zfinx      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_rf_write_ctrl_if.slave  src,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    output logic                  init_done_o
);

    localparam int unsigned NTOT = rf_ntot(FPU, Zfinx);
    localparam logic [ADDR_WIDTH-2:0] K_LAST = (ADDR_WIDTH-1)'(NTOT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        (NTOT == 64) ? '1 : ~(ADDR_WIDTH'(1) << FP_BANK_BIT);

    rf_state_e             state;
    logic [ADDR_WIDTH-2:0] k;

    logic                  run;
    logic                  a_gnt;
    logic                  collide;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [ADDR_WIDTH-1:0] a_addr_req;
    logic [DATA_WIDTH-1:0] a_data_req;

    logic                  a_valid, a_sup, b_valid, b_sup;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_data, b_data;

    always_comb begin
        run           = (state == RUN) && rst_n;
        src.ex_gnt_o  = run & src.ex_we_i;
        src.lsu_gnt_o = run & src.lsu_we_i;
        src.dbg_gnt_o = run & src.dbg_req_i & ~src.lsu_we_i;

        // LSU owns port A whenever it writes; debug only fills idle slots.
        ex_addr    = src.ex_waddr_i & ADDR_MASK;
        a_addr_req = (src.lsu_we_i ? src.lsu_waddr_i : src.dbg_addr_i) & ADDR_MASK;
        a_data_req = src.lsu_we_i ? src.lsu_wdata_i : src.dbg_wdata_i;
        a_gnt      = src.lsu_gnt_o | src.dbg_gnt_o;
        collide    = src.ex_gnt_o & a_gnt & (a_addr_req == ex_addr);

        if (state == CLEAR) begin
            a_valid = 1'b1;
            a_sup   = 1'b0;
            a_addr  = {k, 1'b0};
            a_data  = '0;
            b_valid = 1'b1;
            b_sup   = 1'b0;
            b_addr  = {k, 1'b1};
            b_data  = '0;
        end else begin
            a_valid = a_gnt;
            a_sup   = (a_addr_req == '0) | collide;
            a_addr  = a_addr_req;
            a_data  = a_data_req;
            b_valid = src.ex_gnt_o;
            b_sup   = (ex_addr == '0);
            b_addr  = ex_addr;
            b_data  = src.ex_wdata_i;
        end
    end

    // init_done follows RUN by one cycle so it rises after the last scrub
    // pair has appeared on the ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CLEAR;
            k           <= '0;
            init_done_o <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    init_done_o <= 1'b1;
                end
            endcase
        end
    end

    riscv_rf_wport_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (a_valid),
        .suppress (a_sup),
        .addr     (a_addr),
        .data     (a_data),
        .we       (we_a_o),
        .waddr    (waddr_a_o),
        .wdata    (wdata_a_o)
    );

    riscv_rf_wport_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (b_valid),
        .suppress (b_sup),
        .addr     (b_addr),
        .data     (b_data),
        .we       (we_b_o),
        .waddr    (waddr_b_o),
        .wdata    (wdata_b_o)
    );

endmodule

// File: tb/tb_riscv_rf_write_ctrl.sv
// Directed self-checking bench for riscv_rf_write_ctrl with the FP bank
// present (64-word scrub).
module tb_riscv_rf_write_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] waddr_a_o, waddr_b_o;
    logic [DW-1:0] wdata_a_o, wdata_b_o;
    logic          we_a_o, we_b_o, init_done_o;

    int checks = 0;
    int errors = 0;

    riscv_rf_write_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rf_if ();

    riscv_rf_write_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FPU        (1),
        .Zfinx      (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src         (rf_if),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_a_o      (we_a_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .we_b_o      (we_b_o),
        .init_done_o (init_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rf_if.ex_we_i     = 1'b0;
        rf_if.ex_waddr_i  = '0;
        rf_if.ex_wdata_i  = '0;
        rf_if.lsu_we_i    = 1'b0;
        rf_if.lsu_waddr_i = '0;
        rf_if.lsu_wdata_i = '0;
        rf_if.dbg_req_i   = 1'b0;
        rf_if.dbg_addr_i  = '0;
        rf_if.dbg_wdata_i = '0;
    endtask

    // Checks npairs scrub cycles; a pending debug request must never be granted.
    task automatic scrub_check(input int npairs);
        rf_if.dbg_req_i  = 1'b1;
        rf_if.dbg_addr_i = 6'd3;
        for (int i = 0; i < npairs; i++) begin
            tick();
            chk("scrub_we_a",  we_a_o, 1);
            chk("scrub_addr_a", waddr_a_o, 64'(2 * i));
            chk("scrub_data_a", wdata_a_o, 0);
            chk("scrub_we_b",  we_b_o, 1);
            chk("scrub_addr_b", waddr_b_o, 64'(2 * i + 1));
            chk("scrub_data_b", wdata_b_o, 0);
            chk("scrub_init_done", init_done_o, 0);
            if (i < 31) chk("scrub_dbg_gnt", rf_if.dbg_gnt_o, 0);
            if (i == 30) rf_if.dbg_req_i = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we_a"}, we_a_o, 0);
        chk({tag, "_addr_a"}, waddr_a_o, 0);
        chk({tag, "_we_b"}, we_b_o, 0);
        chk({tag, "_data_b"}, wdata_b_o, 0);
        chk({tag, "_init_done"}, init_done_o, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        rf_if.ex_we_i    = 1'b1;
        rf_if.ex_waddr_i = 6'd3;
        rf_if.ex_wdata_i = 32'h55;
        tick();
        tick();
        check_reset_outputs("reset");
        chk("reset_ex_gnt", rf_if.ex_gnt_o, 0);

        idle_inputs();
        rst_n = 1'b1;
        scrub_check(32);
        tick();
        chk("done_init_done", init_done_o, 1);
        chk("done_we_a", we_a_o, 0);
        chk("done_we_b", we_b_o, 0);

        // Concurrent EX + LSU writes to different addresses
        rf_if.ex_we_i     = 1'b1;
        rf_if.ex_waddr_i  = 6'd5;
        rf_if.ex_wdata_i  = 32'hDEADBEEF;
        rf_if.lsu_we_i    = 1'b1;
        rf_if.lsu_waddr_i = 6'd33;
        rf_if.lsu_wdata_i = 32'h12345678;
        #1;
        chk("conc_ex_gnt", rf_if.ex_gnt_o, 1);
        chk("conc_lsu_gnt", rf_if.lsu_gnt_o, 1);
        tick();
        chk("conc_we_b", we_b_o, 1);
        chk("conc_addr_b", waddr_b_o, 5);
        chk("conc_data_b", wdata_b_o, 32'hDEADBEEF);
        chk("conc_we_a", we_a_o, 1);
        chk("conc_addr_a", waddr_a_o, 33);
        chk("conc_data_a", wdata_a_o, 32'h12345678);

        // Same-address collision: EX wins, port A write dropped
        rf_if.ex_waddr_i  = 6'd7;
        rf_if.ex_wdata_i  = 32'hA;
        rf_if.lsu_waddr_i = 6'd7;
        rf_if.lsu_wdata_i = 32'hB;
        #1;
        chk("coll_ex_gnt", rf_if.ex_gnt_o, 1);
        chk("coll_lsu_gnt", rf_if.lsu_gnt_o, 1);
        tick();
        chk("coll_we_b", we_b_o, 1);
        chk("coll_data_b", wdata_b_o, 32'hA);
        chk("coll_we_a", we_a_o, 0);

        // Debug blocked while LSU holds port A
        rf_if.ex_we_i     = 1'b0;
        rf_if.lsu_waddr_i = 6'd40;
        rf_if.lsu_wdata_i = 32'h1;
        rf_if.dbg_req_i   = 1'b1;
        rf_if.dbg_addr_i  = 6'd9;
        rf_if.dbg_wdata_i = 32'hCAFE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dbg_blocked_gnt", rf_if.dbg_gnt_o, 0);
            tick();
            chk("dbg_blocked_addr_a", waddr_a_o, 40);
            chk("dbg_blocked_we_a", we_a_o, 1);
        end
        rf_if.lsu_we_i = 1'b0;
        #1;
        chk("dbg_gnt", rf_if.dbg_gnt_o, 1);
        tick();
        chk("dbg_we_a", we_a_o, 1);
        chk("dbg_addr_a", waddr_a_o, 9);
        chk("dbg_data_a", wdata_a_o, 32'hCAFE);
        rf_if.dbg_req_i = 1'b0;
        #1;
        chk("dbg_gnt_drop", rf_if.dbg_gnt_o, 0);

        // Address 0 is granted but not written
        rf_if.ex_we_i    = 1'b1;
        rf_if.ex_waddr_i = 6'd0;
        rf_if.ex_wdata_i = 32'hFFFFFFFF;
        #1;
        chk("a0_ex_gnt", rf_if.ex_gnt_o, 1);
        tick();
        chk("a0_we_b", we_b_o, 0);

        idle_inputs();
        tick();
        chk("idle_we_a", we_a_o, 0);
        chk("idle_addr_a", waddr_a_o, 0);
        chk("idle_data_a", wdata_a_o, 0);
        chk("idle_we_b", we_b_o, 0);
        chk("idle_init_done", init_done_o, 1);

        // Reset from RUN, then again mid-scrub at k = 10
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_run");
        rst_n = 1'b1;
        scrub_check(10);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_dbg_gnt", rf_if.dbg_gnt_o, 0);
        check_reset_outputs("mid_rst1");
        tick();
        check_reset_outputs("mid_rst2");
        idle_inputs();
        rst_n = 1'b1;
        scrub_check(32);
        tick();
        chk("rescrub_init_done", init_done_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
